// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - read-side drain engine: registered-read FIFO to valid/ready stream
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  flush,
    output logic [CNT_WIDTH-1:0]  words_out,
    output logic                  idle
);

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q;
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [CNT_WIDTH-1:0]  cnt_q;

    logic       pop;
    logic       capture;
    logic [2:0] pending;

    assign pop     = m_valid & m_ready;
    assign capture = inflight_q;

    // Words already committed to the buffer after this cycle's pop; a strobe
    // is only issued when it is guaranteed a free slot on return.
    assign pending    = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en = reset & ~flush & ~fifo_empty & (pending < 3'd2);

    assign m_valid   = (occ_q != 2'd0);
    assign m_data    = buf_q[head_q];
    assign idle      = (occ_q == 2'd0) & ~inflight_q;
    assign words_out = cnt_q;

    always_comb begin
        occ_d  = occ_q + {1'b0, capture} - {1'b0, pop};
        head_d = head_q ^ pop;
        tail_d = tail_q ^ capture;
        if (flush) begin
            occ_d  = 2'd0;
            head_d = 1'b0;
            tail_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            cnt_q      <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_rd_en;
            head_q     <= head_d;
            tail_q     <= tail_d;
            // Returning data from a strobe issued before a flush is dropped here.
            if (capture && !flush) begin
                buf_q[tail_q] <= fifo_rdata;
            end
            if (pop) begin
                cnt_q <= cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_rdata = 8'h00;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       flush;
    logic [31:0] words_out;
    logic       idle;

    logic       rd_en4;
    logic       m_valid4;
    logic [7:0] m_data4;
    logic [3:0] words_out4;
    logic       idle4;

    logic [7:0] mem [256];
    int         wr_cnt = 0;
    int         rd_ptr = 0;

    int         strb_cnt = 0;
    int         pop_cnt  = 0;
    int         cyc_cnt  = 0;
    logic [7:0] rx [$];
    int         pop_cyc [$];

    int         n_checks = 0;
    int         n_errors = 0;

    fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .fifo_rdata(fifo_rdata), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .flush(flush), .words_out(words_out), .idle(idle)
    );

    fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en4),
        .fifo_rdata(fifo_rdata), .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4),
        .flush(flush), .words_out(words_out4), .idle(idle4)
    );

    always #5 clk = ~clk;

    // Registered-read FIFO model
    assign fifo_empty = (rd_ptr == wr_cnt);
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (fifo_rd_en) begin
            fifo_rdata <= mem[rd_ptr[7:0]];
            rd_ptr     <= rd_ptr + 1;
        end
    end

    // Sink monitor, sampled mid-cycle with inputs stable
    always @(negedge clk) begin
        if (fifo_rd_en) strb_cnt <= strb_cnt + 1;
        if (reset && m_valid && m_ready) begin
            pop_cnt <= pop_cnt + 1;
            rx.push_back(m_data);
            pop_cyc.push_back(cyc_cnt);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] x);
        mem[wr_cnt[7:0]] = x;
        wr_cnt++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic wait_rx(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (rx.size() >= target) break;
            tick();
        end
        check("rx_timeout", rx.size(), target);
    endtask

    int rx_base, strb_base, pop_base, outst, max_out;

    initial begin
        reset = 1'b0; flush = 1'b0; m_ready = 1'b1;

        // Reset state and preloaded drain
        push(8'hA1); push(8'hB2); push(8'hC3);
        repeat (2) tick();
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_idle", idle, 1);
        check("rst_words", words_out, 0);
        reset = 1'b1; #1;
        check("t1_rd_c0", fifo_rd_en, 1);
        tick(); check("t1_rd_c1", fifo_rd_en, 1);
        check("t1_valid_c1", m_valid, 0);
        tick(); check("t1_rd_c2", fifo_rd_en, 1);
        check("t1_valid_c2", m_valid, 1); check("t1_data_c2", m_data, 8'hA1);
        tick(); check("t1_rd_c3", fifo_rd_en, 0);
        check("t1_valid_c3", m_valid, 1); check("t1_data_c3", m_data, 8'hB2);
        tick(); check("t1_valid_c4", m_valid, 1); check("t1_data_c4", m_data, 8'hC3);
        tick(); check("t1_idle_c5", idle, 1); check("t1_words", words_out, 3);
        check("t1_valid_c5", m_valid, 0);

        // Back-pressure
        m_ready = 1'b0;
        do_reset();
        strb_base = strb_cnt; rx_base = rx.size();
        for (int i = 0; i < 10; i++) push(8'h10 + 8'(i));
        repeat (3) tick();
        check("bp_data_early", m_data, 8'h10);
        repeat (5) tick();
        check("bp_strobes", strb_cnt - strb_base, 2);
        check("bp_valid", m_valid, 1);
        check("bp_data_hold", m_data, 8'h10);
        check("bp_rd_en", fifo_rd_en, 0);
        check("bp_idle", idle, 0);
        m_ready = 1'b1;
        wait_rx(rx_base + 10, 40);
        for (int i = 0; i < 10; i++)
            if (rx_base + i < rx.size()) check("bp_order", rx[rx_base + i], 8'h10 + 8'(i));
        if (rx.size() >= rx_base + 10)
            check("bp_no_gaps", pop_cyc[rx_base + 9] - pop_cyc[rx_base], 9);
        check("bp_words", words_out, 10);

        // Alternating ready
        do_reset();
        strb_base = strb_cnt; pop_base = pop_cnt; rx_base = rx.size(); max_out = 0;
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        for (int i = 0; i < 120; i++) begin
            if (rx.size() >= rx_base + 16) break;
            m_ready = (i % 2 == 0);
            #1;
            outst = (strb_cnt - strb_base) - (pop_cnt - pop_base);
            if (outst > max_out) max_out = outst;
            tick();
        end
        check("alt_count", rx.size(), rx_base + 16);
        for (int i = 0; i < 16; i++)
            if (rx_base + i < rx.size()) check("alt_order", rx[rx_base + i], 8'h20 + 8'(i));
        check("alt_words", words_out, 16);
        check("alt_outstanding", (max_out <= 2), 1);

        // Flush with one buffered and one in-flight word
        m_ready = 1'b0;
        do_reset();
        push(8'h40); #1;
        check("fl_rd_c0", fifo_rd_en, 1);
        tick(); tick();
        check("fl_valid_c2", m_valid, 1); check("fl_data_c2", m_data, 8'h40);
        push(8'h41); push(8'h42); #1;
        check("fl_rd_c2", fifo_rd_en, 1);
        tick(); flush = 1'b1; #1;
        check("fl_rd_flush", fifo_rd_en, 0);
        tick(); flush = 1'b0; #1;
        check("fl_valid_c4", m_valid, 0); check("fl_idle_c4", idle, 1);
        check("fl_rd_c4", fifo_rd_en, 1);
        tick(); check("fl_valid_c5", m_valid, 0);
        tick(); check("fl_valid_c6", m_valid, 1); check("fl_data_c6", m_data, 8'h42);
        check("fl_words", words_out, 0);
        m_ready = 1'b1;
        tick(); check("fl_words_pop", words_out, 1); check("fl_valid_c7", m_valid, 0);

        // Reset mid-stream
        push(8'h51); push(8'h52); push(8'h53); push(8'h54);
        tick(); tick();
        check("mr_valid", m_valid, 1); check("mr_data", m_data, 8'h51);
        reset = 1'b0; m_ready = 1'b0; #1;
        check("mr_rd_en_low", fifo_rd_en, 0);
        tick();
        check("mr_valid_after", m_valid, 0); check("mr_data_after", m_data, 0);
        check("mr_words", words_out, 0); check("mr_rd_en", fifo_rd_en, 0);
        check("mr_words4", words_out4, 0);
        reset = 1'b1;

        // Counter wrap: 17 deliveries (two left over in the FIFO plus 15 new)
        m_ready = 1'b1;
        rx_base = rx.size();
        for (int i = 0; i < 15; i++) push(8'h60 + 8'(i));
        wait_rx(rx_base + 17, 80);
        if (rx.size() >= rx_base + 17) begin
            check("wr_first", rx[rx_base], 8'h53);
            check("wr_second", rx[rx_base + 1], 8'h54);
            check("wr_last", rx[rx_base + 16], 8'h6E);
        end
        check("wr_words32", words_out, 17);
        check("wr_words4", words_out4, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
